zmod_link_trainer: RTL

//  Sequences word alignment of the 4-lane zmod LVDS loopback link.
//  - On start, requests the fixed training word on the TX lanes.
//  - Checks each deserialized RX lane against that word and pulses per-lane bitslip until it matches.
//  - Reports per-lane lock/fail status to the AXI register file.

---
 rtl/zmod_link_trainer_if.sv | 39 +++
 rtl/zmod_link_trainer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/zmod_link_trainer_if.sv
// zmod link trainer bus bundle.
// Carries everything the trainer exchanges with the register file and the
// serdes datapath; clk and reset stay outside as plain ports.
//   start        register file -> trainer   one-cycle start/restart pulse
//   rx_data      serdes -> trainer          deserialized words, lane i = [i*W +: W]
//   tx_pattern   trainer -> serdes          transmit the training word on all lanes
//   bitslip      trainer -> serdes          one-cycle bitslip request per lane
//   lane_locked  trainer -> register file   per-lane lock status
//   lane_failed  trainer -> register file   per-lane fail status
//   slip_count   trainer -> register file   bitslips issued per lane, lane i = [i*4 +: 4]
//   busy/done/fail trainer -> register file global status
// modport master: register file / datapath side. modport slave: the trainer.
interface zmod_link_trainer_if #(
    parameter int LANES = 4,
    parameter int W     = 8
);
    logic                 start;
    logic [LANES*W-1:0]   rx_data;
    logic                 tx_pattern;
    logic [LANES-1:0]     bitslip;
    logic [LANES-1:0]     lane_locked;
    logic [LANES-1:0]     lane_failed;
    logic [LANES*4-1:0]   slip_count;
    logic                 busy;
    logic                 done;
    logic                 fail;

    modport master (
        output start, rx_data,
        input  tx_pattern, bitslip, lane_locked, lane_failed, slip_count,
               busy, done, fail
    );

    modport slave (
        input  start, rx_data,
        output tx_pattern, bitslip, lane_locked, lane_failed, slip_count,
               busy, done, fail
    );
endinterface

// File: rtl/zmod_link_trainer.sv
// zmod LVDS loopback word-alignment trainer.
// Requests the training word on TX, compares every RX lane against it and
// issues per-lane bitslips until each lane sees LOCK_COUNT consecutive
// matches (LOCKED) or runs out of slips / time (FAILED).
// Ports:
//   clk    in  word clock, all logic on posedge
//   reset  in  synchronous, active-high
//   bus    zmod_link_trainer_if.slave (start, rx_data in; tx_pattern,
//          bitslip, lane_locked, lane_failed, slip_count, busy, done, fail out)
//
// Global FSM
//   state   | meaning
//   G_IDLE  | after reset, waiting for start
//   G_TRAIN | pattern on TX, lanes searching for alignment
//   G_DONE  | all lanes terminal or timed out, status held
// Lane FSM
//   state    | meaning
//   L_SEARCH | counting consecutive matching words
//   L_WAIT   | settling after a bitslip, rx ignored
//   L_LOCKED | aligned, terminal for this run
//   L_FAILED | slips exhausted or timed out, terminal for this run
module zmod_link_trainer #(
    parameter int             LANES      = 4,
    parameter int             W          = 8,
    parameter logic [W-1:0]   PATTERN    = 8'h5C,
    parameter int             LOCK_COUNT = 64,
    parameter int             SLIP_WAIT  = 8,
    parameter int             MAX_SLIPS  = W,
    parameter int             TIMEOUT    = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    zmod_link_trainer_if.slave   bus
);
    localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [3:0]    SLIP_MAX   = 4'(MAX_SLIPS);
    localparam logic [15:0]   TOUT_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {G_IDLE, G_TRAIN, G_DONE} gstate_t;
    typedef enum logic [1:0] {L_SEARCH, L_WAIT, L_LOCKED, L_FAILED} lstate_t;

    gstate_t          g_state, g_next;
    lstate_t          l_state   [LANES];
    lstate_t          l_next    [LANES];
    logic [MW-1:0]    match_cnt [LANES];
    logic [MW-1:0]    match_nxt [LANES];
    logic [3:0]       slip_cnt  [LANES];
    logic [3:0]       slip_nxt  [LANES];
    logic [WW-1:0]    wait_cnt  [LANES];
    logic [WW-1:0]    wait_nxt  [LANES];
    logic [15:0]      tout_cnt, tout_nxt;
    logic [LANES-1:0] slip_q, slip_d;
    logic             all_term, tout_hit, clear;

    logic [LANES-1:0]   locked_v, failed_v;
    logic [LANES*4-1:0] slipc_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            g_state  <= G_IDLE;
            tout_cnt <= '0;
            slip_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                l_state[i]   <= L_SEARCH;
                match_cnt[i] <= '0;
                slip_cnt[i]  <= '0;
                wait_cnt[i]  <= '0;
            end
        end else begin
            g_state  <= g_next;
            tout_cnt <= tout_nxt;
            slip_q   <= slip_d;
            for (int i = 0; i < LANES; i++) begin
                l_state[i]   <= l_next[i];
                match_cnt[i] <= match_nxt[i];
                slip_cnt[i]  <= slip_nxt[i];
                wait_cnt[i]  <= wait_nxt[i];
            end
        end
    end

    always_comb begin
        all_term = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (l_state[i] != L_LOCKED && l_state[i] != L_FAILED) begin
                all_term = 1'b0;
            end
        end
        tout_hit = (g_state == G_TRAIN) && (tout_cnt == TOUT_LAST);
        // start only acts outside TRAIN; it clears lanes on the same edge
        clear    = (g_state != G_TRAIN) && bus.start;

        g_next   = g_state;
        tout_nxt = tout_cnt;
        case (g_state)
            G_IDLE:  if (bus.start) g_next = G_TRAIN;
            G_TRAIN: begin
                tout_nxt = tout_cnt + 16'd1;
                if (all_term || tout_hit) g_next = G_DONE;
            end
            G_DONE:  if (bus.start) g_next = G_TRAIN;
            default: g_next = G_IDLE;
        endcase
        if (clear) tout_nxt = '0;

        for (int i = 0; i < LANES; i++) begin
            l_next[i]    = l_state[i];
            match_nxt[i] = match_cnt[i];
            slip_nxt[i]  = slip_cnt[i];
            wait_nxt[i]  = wait_cnt[i];
            slip_d[i]    = 1'b0;
            if (clear) begin
                l_next[i]    = L_SEARCH;
                match_nxt[i] = '0;
                slip_nxt[i]  = '0;
                wait_nxt[i]  = '0;
            end else if (g_state == G_TRAIN) begin
                if (tout_hit) begin
                    // timeout wins over any per-lane progress on this edge
                    if (l_state[i] != L_LOCKED) l_next[i] = L_FAILED;
                end else begin
                    case (l_state[i])
                        L_SEARCH: begin
                            if (bus.rx_data[i*W +: W] == PATTERN) begin
                                if (match_cnt[i] == MATCH_LAST) begin
                                    l_next[i] = L_LOCKED;
                                end else begin
                                    match_nxt[i] = match_cnt[i] + 1'b1;
                                end
                            end else begin
                                match_nxt[i] = '0;
                                if (slip_cnt[i] >= SLIP_MAX) begin
                                    l_next[i] = L_FAILED;
                                end else begin
                                    slip_d[i]   = 1'b1;
                                    slip_nxt[i] = (slip_cnt[i] == 4'hF) ? slip_cnt[i]
                                                                        : slip_cnt[i] + 4'd1;
                                    wait_nxt[i] = '0;
                                    l_next[i]   = L_WAIT;
                                end
                            end
                        end
                        L_WAIT: begin
                            if (wait_cnt[i] == WAIT_LAST) begin
                                l_next[i]    = L_SEARCH;
                                match_nxt[i] = '0;
                            end else begin
                                wait_nxt[i] = wait_cnt[i] + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        locked_v = '0;
        failed_v = '0;
        slipc_v  = '0;
        for (int i = 0; i < LANES; i++) begin
            locked_v[i]        = (l_state[i] == L_LOCKED);
            failed_v[i]        = (l_state[i] == L_FAILED);
            slipc_v[i*4 +: 4]  = slip_cnt[i];
        end
    end

    assign bus.tx_pattern  = (g_state == G_TRAIN);
    assign bus.busy        = (g_state == G_TRAIN);
    assign bus.done        = (g_state == G_DONE);
    assign bus.fail        = (g_state == G_DONE) && (|failed_v);
    assign bus.bitslip     = slip_q;
    assign bus.lane_locked = locked_v;
    assign bus.lane_failed = failed_v;
    assign bus.slip_count  = slipc_v;
endmodule
